// File: rtl/vita49_trig_gate.sv
`default_nettype none
// ============================================================================
// Module   : vita49_trig_gate
// Brief    : Multi-window VITA-49 timestamp trigger with a packet-boundary
//            AXI4-Stream gate (whole packets passed or dropped).
// Revision : 1.0
// ============================================================================
module vita49_trig_gate #(
  parameter int C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int C_NUM_WIN              = 4,
  parameter int C_TSI_WIDTH            = 32,
  parameter int C_TSF_WIDTH            = 64,
  parameter int C_CNT_WIDTH            = 32
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
  input  logic                                  S_AXIS_TLAST,
  input  logic                                  S_AXIS_TVALID,
  output logic                                  S_AXIS_TREADY,
  output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  input  logic [31:0]                           ctrl,
  input  logic [C_TSI_WIDTH-1:0]                tsi_up,
  input  logic [C_TSF_WIDTH-1:0]                tsf_up,
  input  logic [C_TSI_WIDTH-1:0]                tsi,
  input  logic [C_TSF_WIDTH-1:0]                tsf,
  output logic                                  trig,
  output logic [C_NUM_WIN-1:0]                  win_active,
  output logic [31:0]                           status,
  output logic [C_CNT_WIDTH-1:0]                pkt_pass_cnt,
  output logic [C_CNT_WIDTH-1:0]                pkt_drop_cnt
);

  localparam logic [C_CNT_WIDTH-1:0] c_CNT_ONE = C_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ARMED  = 2'd1,
    W_ACTIVE = 2'd2,
    W_DONE   = 2'd3
  } win_state_t;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_PASS = 2'd1,
    G_DROP = 2'd2
  } gate_state_t;

  logic       w_en, w_clear, w_passthru, w_gate_en;
  logic       w_wr_on, w_wr_off, w_arm, w_disarm;
  logic [3:0] w_win_sel;
  logic       w_rst_any;
  logic       w_unused;

  assign w_en       = ctrl[0];
  assign w_clear    = ctrl[1];
  assign w_passthru = ctrl[2];
  assign w_gate_en  = ctrl[3];
  assign w_wr_on    = ctrl[4];
  assign w_wr_off   = ctrl[5];
  assign w_arm      = ctrl[6];
  assign w_disarm   = ctrl[7];
  assign w_win_sel  = ctrl[11:8];
  assign w_unused   = ^ctrl[31:12];
  assign w_rst_any  = !AXIS_ARESETN || w_clear;

  // Single registered copy of current time; every window compares against it.
  logic [C_TSI_WIDTH-1:0] r_tsi;
  logic [C_TSF_WIDTH-1:0] r_tsf;

  always_ff @(posedge AXIS_ACLK) begin
    r_tsi <= tsi;
    r_tsf <= tsf;
  end

  function automatic logic f_ts_ge(
    input logic [C_TSI_WIDTH-1:0] a_tsi,
    input logic [C_TSF_WIDTH-1:0] a_tsf,
    input logic [C_TSI_WIDTH-1:0] b_tsi,
    input logic [C_TSF_WIDTH-1:0] b_tsf
  );
    return (a_tsi > b_tsi) || ((a_tsi == b_tsi) && (a_tsf >= b_tsf));
  endfunction

  logic [C_NUM_WIN-1:0] w_active;
  logic [C_NUM_WIN-1:0] w_missed_set;
  logic [C_NUM_WIN-1:0] w_wr_err_set;

  for (genvar i = 0; i < C_NUM_WIN; i++) begin : g_win
    win_state_t             r_state;
    logic [C_TSI_WIDTH-1:0] r_start_tsi, r_stop_tsi;
    logic [C_TSF_WIDTH-1:0] r_start_tsf, r_stop_tsf;
    logic                   w_sel, w_writable, w_hit_start, w_hit_stop;

    assign w_sel       = (w_win_sel == 4'(i));
    assign w_writable  = (r_state == W_IDLE) || (r_state == W_DONE);
    assign w_hit_start = f_ts_ge(r_tsi, r_tsf, r_start_tsi, r_start_tsf);
    assign w_hit_stop  = f_ts_ge(r_tsi, r_tsf, r_stop_tsi, r_stop_tsf);

    always_ff @(posedge AXIS_ACLK) begin
      if (w_rst_any) begin
        r_state     <= W_IDLE;
        r_start_tsi <= '1;
        r_start_tsf <= '1;
        r_stop_tsi  <= '1;
        r_stop_tsf  <= '1;
      end else begin
        if (w_sel && w_wr_on && w_writable) begin
          r_start_tsi <= tsi_up;
          r_start_tsf <= tsf_up;
        end
        if (w_sel && w_wr_off && w_writable) begin
          r_stop_tsi <= tsi_up;
          r_stop_tsf <= tsf_up;
        end
        if (w_en) begin
          if (w_sel && w_disarm) begin
            r_state <= W_IDLE;
          end else if (w_sel && w_arm && w_writable) begin
            r_state <= W_ARMED;
          end else begin
            // Stop wins over start so a stale window never produces a pulse.
            case (r_state)
              W_ARMED: begin
                if (w_hit_stop)       r_state <= W_DONE;
                else if (w_hit_start) r_state <= W_ACTIVE;
              end
              W_ACTIVE: begin
                if (w_hit_stop) r_state <= W_DONE;
              end
              default: ;
            endcase
          end
        end
      end
    end

    assign w_active[i]     = (r_state == W_ACTIVE);
    assign w_missed_set[i] = w_en && !(w_sel && w_disarm) &&
                             (r_state == W_ARMED) && w_hit_stop;
    assign w_wr_err_set[i] = w_sel && (w_wr_on || w_wr_off) && !w_writable;
  end

  logic r_trig, r_missed, r_wr_err;

  always_ff @(posedge AXIS_ACLK) begin
    if (w_rst_any) begin
      r_trig   <= 1'b0;
      r_missed <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_trig <= w_passthru || (|w_active);
      if (|w_missed_set) r_missed <= 1'b1;
      if (|w_wr_err_set) r_wr_err <= 1'b1;
    end
  end

  gate_state_t            r_gstate;
  logic [C_CNT_WIDTH-1:0] r_pass_cnt, r_drop_cnt;
  logic                   w_decision, w_pass_beat, w_m_tvalid, w_s_tready, w_hs;

  assign w_decision = r_trig || w_passthru;

  // The head beat is decided in G_IDLE itself so a packet never waits a cycle.
  always_comb begin
    w_pass_beat = 1'b0;
    case (r_gstate)
      G_PASS:  w_pass_beat = 1'b1;
      G_DROP:  w_pass_beat = 1'b0;
      default: w_pass_beat = w_decision;
    endcase
    if (!w_gate_en) w_pass_beat = 1'b1;
  end

  always_comb begin
    w_m_tvalid = 1'b0;
    w_s_tready = 1'b0;
    if (AXIS_ARESETN) begin
      if (w_pass_beat) begin
        w_m_tvalid = S_AXIS_TVALID;
        w_s_tready = M_AXIS_TREADY;
      end else begin
        w_m_tvalid = 1'b0;
        w_s_tready = 1'b1;
      end
    end
  end

  assign w_hs = S_AXIS_TVALID && w_s_tready;

  always_ff @(posedge AXIS_ACLK) begin
    if (w_rst_any) begin
      r_gstate   <= G_IDLE;
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (w_hs) begin
      if (S_AXIS_TLAST) begin
        r_gstate <= G_IDLE;
        if (w_pass_beat) r_pass_cnt <= r_pass_cnt + c_CNT_ONE;
        else             r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
      end else if (r_gstate == G_IDLE) begin
        r_gstate <= w_pass_beat ? G_PASS : G_DROP;
      end
    end
  end

  assign S_AXIS_TREADY = w_s_tready;
  assign M_AXIS_TVALID = w_m_tvalid;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;

  assign trig         = r_trig;
  assign win_active   = w_active;
  assign pkt_pass_cnt = r_pass_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
  assign status       = {16'd0, 6'd0, r_gstate, 4'd0,
                         r_wr_err, r_missed, (r_gstate != G_IDLE), r_trig};

endmodule
`default_nettype wire

// File: doc/vita49_trig_gate.md
Name: vita49_trig_gate

Overview:
- Multi-window successor to the single on/off VITA-49 timestamp trigger.
- Holds C_NUM_WIN independently armed trigger windows, each a start and stop timestamp (integer seconds plus fractional count). Their ORed state drives `trig`.
- `trig` also gates an AXI4-Stream sample path on packet boundaries: whole packets are passed or dropped, never truncated.
- Sits between the timing unit / processor register bank and the downstream VITA-49 packetiser.

Parameters:
- C_AXIS_TDATA_NUM_BYTES, 4, stream width in bytes.
- C_NUM_WIN, 4, number of trigger windows (1..16).
- C_TSI_WIDTH, 32, integer-seconds timestamp width.
- C_TSF_WIDTH, 64, fractional timestamp width.
- C_CNT_WIDTH, 32, packet counter width.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESETN  in  1  synchronous reset, active low.
- S_AXIS_TDATA/TSTRB/TLAST/TVALID  in  8*NB/NB/1/1  input stream.
- S_AXIS_TREADY  out  1  input stream ready.
- M_AXIS_TDATA/TSTRB/TLAST/TVALID  out  8*NB/NB/1/1  output stream.
- M_AXIS_TREADY  in  1  output stream ready.
- ctrl  in  32  control bits:
  - [0] en
  - [1] clear (level; resets windows and counters)
  - [2] passthrough
  - [3] gate_en
  - [4] wr_on strobe
  - [5] wr_off strobe
  - [6] arm strobe
  - [7] disarm strobe
  - [11:8] win_sel
- tsi_up  in  C_TSI_WIDTH  timestamp upload, seconds.
- tsf_up  in  C_TSF_WIDTH  timestamp upload, fraction.
- tsi  in  C_TSI_WIDTH  current time, seconds.
- tsf  in  C_TSF_WIDTH  current time, fraction.
- trig  out  1  registered trigger.
- win_active  out  C_NUM_WIN  per-window ACTIVE flags.
- status  out  32  status word:
  - [0] trig
  - [1] gate state != IDLE
  - [2] sticky missed-window
  - [3] sticky write-while-armed error
  - [15:8] gate state
- pkt_pass_cnt  out  C_CNT_WIDTH  packets passed.
- pkt_drop_cnt  out  C_CNT_WIDTH  packets dropped.

Behaviour:

Reset and clear:
- Reset (AXIS_ARESETN=0 at a clock edge) or clear=1:
  - all windows go to IDLE, start/stop = all-ones, trig=0;
  - counters = 0, sticky bits = 0, gate FSM = G_IDLE.
- Reset mid-packet also forces G_IDLE.
- Outputs during reset: M_AXIS_TVALID=0, S_AXIS_TREADY=0.

Timestamps and matching:
- tsi/tsf are registered once. All comparisons use the registered copy, ts_r.
- ts_r >= T means (tsi_r > T.tsi) | (tsi_r == T.tsi & tsf_r >= T.tsf); both comparisons are unsigned.
- win_sel >= C_NUM_WIN: strobe ignored, no error flagged.

Window writes:
- wr_on / wr_off load tsi_up/tsf_up into the start / stop of window win_sel. Only allowed in IDLE or DONE.
- A write in ARMED or ACTIVE is dropped and sets sticky bit [3].
- Strobes are level-sampled every cycle. Software pulses them for one cycle.

Per-window FSM (IDLE, ARMED, ACTIVE, DONE), evaluated only while en=1; frozen while en=0:
- arm: IDLE/DONE -> ARMED. Ignored in ARMED or ACTIVE.
- disarm: any state -> IDLE. Highest priority after reset/clear.
- ARMED:
  - ts_r >= stop -> DONE, set sticky missed [2]. Stop is checked before start.
  - else ts_r >= start -> ACTIVE.
- ACTIVE: ts_r >= stop -> DONE.
- start >= stop is legal and yields an immediate DONE plus missed.
- Windows are one-shot; re-arm is required.

Trigger:
- trig_next = passthrough | OR(window ACTIVE).
- trig is registered.
- Latency: tsi/tsf reaching start at edge k -> ts_r at k+1 -> window ACTIVE at k+2 -> trig=1 at k+3.

Gate FSM (G_IDLE, G_PASS, G_DROP):
- gate_en=0:
  - stream is a pure combinational passthrough (TVALID/TREADY wired through);
  - FSM still tracks TLAST;
  - every packet counts as passed.
- G_IDLE: packet head = first beat with S_AXIS_TVALID. Decision d = trig | passthrough, evaluated combinationally in the same cycle (no bubble).
  - d=1: behaves as G_PASS for that beat.
  - d=0: behaves as G_DROP for that beat.
- Transitions:
  - G_IDLE -> G_PASS or G_DROP on a head beat with TLAST=0.
  - A one-beat packet (head beat with TLAST=1) completes in G_IDLE: the FSM stays in G_IDLE and the packet is counted by its decision.
- G_PASS:
  - M_AXIS_TVALID=S_AXIS_TVALID, S_AXIS_TREADY=M_AXIS_TREADY.
  - Handshake with TLAST -> G_IDLE, pkt_pass_cnt+1.
- G_DROP:
  - S_AXIS_TREADY=1, M_AXIS_TVALID=0.
  - Accepted TLAST -> G_IDLE, pkt_drop_cnt+1.
- trig changes mid-packet never alter the current decision.
- TDATA/TSTRB/TLAST are always wired through.
- Counters wrap modulo 2^C_CNT_WIDTH.

Test Plan:
- Arm win0 start=(100,0) stop=(100,500); sweep tsf 0..1000 at tsi=100 -> trig rises 3 clocks after tsf=0 is presented, falls 3 clocks after tsf=500; win0 reaches DONE.
- Arm win1 with stop=(50,0) while tsi=60 -> win1 DONE in 2 clocks, status[2]=1, trig stays 0.
- gate_en=1, trig=0, send 3 packets of 4 beats -> zero M_AXIS_TVALID, S_AXIS_TREADY=1 throughout, pkt_drop_cnt=3. Then raise trig mid-4th packet -> 4th packet still dropped, 5th passed.
- trig drops during beat 2 of a 6-beat passing packet with M_AXIS_TREADY toggling 50% -> all 6 beats delivered, pkt_pass_cnt=1.
- wr_on to an ARMED window -> start unchanged, status[3]=1. clear -> all counters/sticky bits 0, windows IDLE.
- Assert AXIS_ARESETN=0 for 1 clock mid-packet in G_PASS -> next cycle G_IDLE, trig=0, counters 0. The following packet head is decided fresh.
